// File: rtl/seg_pkg.sv
// Purpose: shared 7-segment definitions: glyph table, {dp,hex} code type, scan FSM states.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package seg_pkg;

    // Display code recovered per digit: {dp, hex[3:0]}
    typedef logic [4:0] seg_code_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } scan_state_t;

    // Segment patterns {g,f,e,d,c,b,a}, active high, indexed by hex value.
    // Element 15 is listed first in the concatenation.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    function automatic seg_code_t make_code(input logic dp, input logic [3:0] hex);
        return {dp, hex};
    endfunction

endpackage

// File: rtl/seg_pattern_lookup.sv
// Purpose: map a 7-bit segment pattern to its hex glyph index (hit), or flag it blank.
// Latency: combinational.
// Backpressure: none.
// Ports: pattern (7-bit {g..a}) in; hit, blank, idx[3:0] out.
module seg_pattern_lookup
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = 4'h0;
        // Table entries are unique, so at most one iteration matches.
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_PATTERNS[i]) begin
                hit = 1'b1;
                idx = 4'(i);
            end
        end
    end

    assign blank = (pattern == 7'h00);

endmodule

// File: rtl/seg_scan_reader.sv
// Purpose: watch a multiplexed 7-seg bus and recover the {dp,hex} code shown on each digit.
// Latency: inputs steady over STABLE_CYCLES edges -> slot written on the next edge, strobe visible after it.
// Backpressure: none; a passive observer, outputs are pulses/levels with no handshake.
// Ports: clk, rst_n (async, active low), an_sel (one-hot digit select), seg_in {dp,g..a},
//        clr (sync clear); code_out / code_valid per slot, update_stb/update_idx,
//        err_pattern, err_sel pulses.
// Build option: define SEG_SCAN_ACTIVE_LOW_EN for common-anode boards (an_sel/seg_in inverted on entry).
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [NUM_DIGITS-1:0]                               an_sel,
    input  logic [7:0]                                          seg_in,
    input  logic                                                clr,
    output logic [NUM_DIGITS*5-1:0]                             code_out,
    output logic [NUM_DIGITS-1:0]                               code_valid,
    output logic                                                update_stb,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] update_idx,
    output logic                                                err_pattern,
    output logic                                                err_sel
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Polarity-normalised bus, before the sample register
    logic [NUM_DIGITS-1:0] an_raw;
    logic [7:0]            seg_raw;

`ifdef SEG_SCAN_ACTIVE_LOW_EN
    assign an_raw  = ~an_sel;
    assign seg_raw = ~seg_in;
`else
    assign an_raw  = an_sel;
    assign seg_raw = seg_in;
`endif

    // Sample stage and the sample before it
    logic [NUM_DIGITS-1:0] an_s_q, an_p_q;
    logic [7:0]            seg_s_q, seg_p_q;

    scan_state_t                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_inc;
    logic [NUM_DIGITS-1:0][4:0]  code_q;
    logic [NUM_DIGITS-1:0]       valid_q;
    logic                        update_stb_q, err_pattern_q, err_sel_q;
    logic [IDX_W-1:0]            update_idx_q;

    logic             changed, an_zero, an_onehot, an_multi, commit;
    logic [IDX_W-1:0] sel_idx;
    logic             lk_hit, lk_blank;
    logic [3:0]       lk_idx;

    assign changed   = (an_s_q != an_p_q) || (seg_s_q != seg_p_q);
    assign an_zero   = (an_s_q == '0);
    assign an_onehot = $onehot(an_s_q);
    assign an_multi  = !an_zero && !an_onehot;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_s_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    seg_pattern_lookup u_lookup (
        .pattern (seg_s_q[6:0]),
        .hit     (lk_hit),
        .blank   (lk_blank),
        .idx     (lk_idx)
    );

    // Next state / dwell counter. A change restarts the dwell at 1 (the new
    // sample itself counts); the commit fires on the edge the count reaches
    // STABLE_CYCLES and parks the FSM in HOLD until the bus moves again.
    always_comb begin
        cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (changed) begin
            if (an_onehot) begin
                cnt_d   = CNT_ONE;
                state_d = SETTLE;
            end else begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        end else if (state_q == SETTLE) begin
            cnt_d = cnt_inc;
        end
        commit = an_onehot && (state_d == SETTLE) && (cnt_d == CNT_MAX);
        if (commit) begin
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s_q        <= '0;
            an_p_q        <= '0;
            seg_s_q       <= '0;
            seg_p_q       <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            code_q        <= '0;
            valid_q       <= '0;
            update_stb_q  <= 1'b0;
            update_idx_q  <= '0;
            err_pattern_q <= 1'b0;
            err_sel_q     <= 1'b0;
        end else begin
            an_s_q        <= an_raw;
            seg_s_q       <= seg_raw;
            an_p_q        <= an_s_q;
            seg_p_q       <= seg_s_q;
            update_stb_q  <= 1'b0;
            err_pattern_q <= 1'b0;
            // Only on the edge the select moves to a new multi-hot value
            err_sel_q     <= an_multi && (an_s_q != an_p_q);

            if (clr) begin
                // Clear overrides any commit decided this edge
                code_q  <= '0;
                valid_q <= '0;
                state_q <= an_onehot ? SETTLE : IDLE;
                cnt_q   <= an_onehot ? CNT_ONE : '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (commit) begin
                    if (lk_hit) begin
                        code_q[sel_idx]  <= make_code(seg_s_q[7], lk_idx);
                        valid_q[sel_idx] <= 1'b1;
                        update_stb_q     <= 1'b1;
                        update_idx_q     <= sel_idx;
                    end else if (lk_blank) begin
                        valid_q[sel_idx] <= 1'b0;
                        update_stb_q     <= 1'b1;
                        update_idx_q     <= sel_idx;
                    end else begin
                        valid_q[sel_idx] <= 1'b0;
                        err_pattern_q    <= 1'b1;
                    end
                end
            end
        end
    end

    assign code_out    = code_q;
    assign code_valid  = valid_q;
    assign update_stb  = update_stb_q;
    assign update_idx  = update_idx_q;
    assign err_pattern = err_pattern_q;
    assign err_sel     = err_sel_q;

endmodule
